uart_axi_fifo: RTL



---
 rtl/uart_axi_fifo.sv | 283 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_axi_fifo.sv
// AXI4-Lite UART with TX/RX FIFOs, sticky error flags, FIFO flush and a level interrupt.
// One frame: start bit, 8 data bits LSB first, parity bit, one stop bit.
module uart_axi_fifo #(
    parameter int CLK_FREQUENCY = 100_000_000,
    parameter int BAUD_RATE     = 115_200,
    parameter bit PARITY        = 1'b1,
    parameter int TX_FIFO_DEPTH = 16,
    parameter int RX_FIFO_DEPTH = 16
) (
    input  logic        s_axi_aclk,
    input  logic        s_axi_aresetn,
    input  logic [3:0]  s_axi_awaddr,
    input  logic [2:0]  s_axi_awprot,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    input  logic [3:0]  s_axi_araddr,
    input  logic [2:0]  s_axi_arprot,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    input  logic        rx_in,
    output logic        tx_out,
    output logic        irq
);

    localparam int CLKS     = CLK_FREQUENCY / BAUD_RATE;
    localparam int CNT_W    = $clog2(CLKS + 1);
    localparam int TX_AW    = $clog2(TX_FIFO_DEPTH);
    localparam int RX_AW    = $clog2(RX_FIFO_DEPTH);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS / 2 - 1);

    function automatic logic parity_of(input logic [7:0] d);
        return PARITY ? ~(^d) : (^d);
    endfunction

    logic              unused_bits;
    logic              wr_en, wr_byte, rd_en;
    logic [1:0]        wr_addr, rd_addr;
    logic [1:0]        ctrl_ie;
    logic [2:0]        sticky, sticky_set, sticky_clr;
    logic              tx_flush, rx_flush;
    logic [31:0]       status, rd_data;
    logic [1:0]        rd_resp;

    logic [7:0]        tx_mem [TX_FIFO_DEPTH];
    logic [TX_AW-1:0]  tx_wptr, tx_rptr;
    logic [TX_AW:0]    tx_count;
    logic              tx_empty, tx_full, tx_push, tx_wr, tx_pop, tx_drop_set;
    logic [7:0]        tx_head;
    logic              tx_busy, tx_last, tx_start;
    logic [CNT_W-1:0]  tx_cnt;
    logic [3:0]        tx_bit;
    logic [10:0]       tx_shift;

    logic [7:0]        rx_mem [RX_FIFO_DEPTH];
    logic [RX_AW-1:0]  rx_wptr, rx_rptr;
    logic [RX_AW:0]    rx_count;
    logic              rx_empty, rx_full, rx_wr, rx_pop;
    logic              rx_s1, rx_s2, rx_busy;
    logic [CNT_W-1:0]  rx_cnt;
    logic [3:0]        rx_bit;
    logic [8:0]        rx_shift;
    logic              rx_vld_p1, rx_perr_p1;
    logic [7:0]        rx_byte_p1;

    assign unused_bits = &{1'b0, s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0],
                           s_axi_araddr[1:0], s_axi_wdata[31:8], s_axi_wstrb[3:1]};

    // AXI side: the register side effect happens in the cycle the ready pulses
    assign wr_en   = s_axi_awready;
    assign wr_addr = s_axi_awaddr[3:2];
    assign wr_byte = wr_en && s_axi_wstrb[0];
    assign rd_en   = s_axi_arready;
    assign rd_addr = s_axi_araddr[3:2];

    assign tx_push     = wr_byte && (wr_addr == 2'd0);
    assign tx_wr       = tx_push && (!tx_full || tx_pop);
    assign tx_drop_set = tx_push && !tx_wr;
    assign tx_flush    = wr_byte && (wr_addr == 2'd3) && s_axi_wdata[3];
    assign rx_flush    = wr_byte && (wr_addr == 2'd3) && s_axi_wdata[2];
    assign sticky_clr  = (wr_byte && (wr_addr == 2'd2)) ? s_axi_wdata[6:4] : 3'b000;
    assign rx_pop      = rd_en && (rd_addr == 2'd1) && !rx_empty;

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= 2'b00;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
            s_axi_rresp   <= 2'b00;
        end else begin
            s_axi_awready <= s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid && !s_axi_awready;
            s_axi_wready  <= s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid && !s_axi_awready;
            if (wr_en) begin
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= tx_drop_set ? 2'b10 : 2'b00;
            end else if (s_axi_bvalid && s_axi_bready) begin
                s_axi_bvalid <= 1'b0;
            end
            s_axi_arready <= s_axi_arvalid && !s_axi_rvalid && !s_axi_arready;
            if (rd_en) begin
                s_axi_rvalid <= 1'b1;
                s_axi_rdata  <= rd_data;
                s_axi_rresp  <= rd_resp;
            end else if (s_axi_rvalid && s_axi_rready) begin
                s_axi_rvalid <= 1'b0;
            end
        end
    end

    assign status = {8'd0, 8'(tx_count), 8'(rx_count), 1'b0, sticky,
                     tx_full, tx_empty, rx_full, !rx_empty};

    always_comb begin
        rd_data = '0;
        rd_resp = 2'b00;
        case (rd_addr)
            2'd1: begin
                if (rx_empty) rd_resp = 2'b10;
                else          rd_data = {24'd0, rx_mem[rx_rptr]};
            end
            2'd2:    rd_data = status;
            2'd3:    rd_data = {30'd0, ctrl_ie};
            default: rd_data = '0;
        endcase
    end

    // Control, sticky flags (set beats clear) and registered interrupt
    assign sticky_set = {tx_drop_set, rx_vld_p1 && rx_perr_p1, rx_vld_p1 && !rx_wr};

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            ctrl_ie <= 2'b00;
            sticky  <= 3'b000;
            irq     <= 1'b0;
        end else begin
            if (wr_byte && (wr_addr == 2'd3)) ctrl_ie <= s_axi_wdata[1:0];
            sticky <= (sticky & ~sticky_clr) | sticky_set;
            irq    <= (ctrl_ie[0] && !rx_empty) || (ctrl_ie[1] && tx_empty && !tx_busy);
        end
    end

    // TX FIFO; a push into a full FIFO is accepted when the head pops in the same cycle
    assign tx_empty = (tx_count == '0);
    assign tx_full  = (tx_count == (TX_AW+1)'(TX_FIFO_DEPTH));
    assign tx_head  = tx_mem[tx_rptr];

    always_ff @(posedge s_axi_aclk) begin
        if (tx_wr) tx_mem[tx_wptr] <= s_axi_wdata[7:0];
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_count <= '0;
        end else if (tx_flush) begin
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_count <= '0;
        end else begin
            if (tx_wr)  tx_wptr <= tx_wptr + TX_AW'(1);
            if (tx_pop) tx_rptr <= tx_rptr + TX_AW'(1);
            tx_count <= tx_count + (TX_AW+1)'(tx_wr) - (TX_AW+1)'(tx_pop);
        end
    end

    // TX core; the next frame loads on the last stop-bit cycle so frames abut
    assign tx_last  = tx_busy && (tx_bit == 4'd10) && (tx_cnt == BIT_END);
    assign tx_start = !tx_empty && (!tx_busy || tx_last);
    assign tx_pop   = tx_start;
    assign tx_out   = tx_busy ? tx_shift[0] : 1'b1;

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            tx_busy  <= 1'b0;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '1;
        end else if (tx_start) begin
            tx_busy  <= 1'b1;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= {1'b1, parity_of(tx_head), tx_head, 1'b0};
        end else if (tx_busy) begin
            if (tx_cnt == BIT_END) begin
                tx_cnt   <= '0;
                tx_shift <= {1'b1, tx_shift[10:1]};
                if (tx_bit == 4'd10) tx_busy <= 1'b0;
                else                 tx_bit  <= tx_bit + 4'd1;
            end else begin
                tx_cnt <= tx_cnt + CNT_W'(1);
            end
        end
    end

    // RX core: synchronise, qualify the start bit at mid-bit, then sample every bit centre
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_busy    <= 1'b0;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            rx_vld_p1  <= 1'b0;
            rx_perr_p1 <= 1'b0;
            rx_byte_p1 <= '0;
        end else begin
            rx_s1     <= rx_in;
            rx_s2     <= rx_s1;
            rx_vld_p1 <= 1'b0;
            if (!rx_busy) begin
                if (!rx_s2) begin
                    rx_busy <= 1'b1;
                    rx_cnt  <= '0;
                    rx_bit  <= '0;
                end
            end else if (rx_bit == 4'd0) begin
                if (rx_cnt == HALF_END) begin
                    rx_cnt <= '0;
                    if (rx_s2) rx_busy <= 1'b0;
                    else       rx_bit  <= 4'd1;
                end else begin
                    rx_cnt <= rx_cnt + CNT_W'(1);
                end
            end else if (rx_cnt == BIT_END) begin
                rx_cnt <= '0;
                if (rx_bit == 4'd10) begin
                    rx_busy    <= 1'b0;
                    rx_vld_p1  <= 1'b1;
                    rx_byte_p1 <= rx_shift[7:0];
                    rx_perr_p1 <= parity_of(rx_shift[7:0]) != rx_shift[8];
                end else begin
                    rx_shift <= {rx_s2, rx_shift[8:1]};
                    rx_bit   <= rx_bit + 4'd1;
                end
            end else begin
                rx_cnt <= rx_cnt + CNT_W'(1);
            end
        end
    end

    // RX FIFO
    assign rx_empty = (rx_count == '0);
    assign rx_full  = (rx_count == (RX_AW+1)'(RX_FIFO_DEPTH));
    assign rx_wr    = rx_vld_p1 && (!rx_full || rx_pop);

    always_ff @(posedge s_axi_aclk) begin
        if (rx_wr) rx_mem[rx_wptr] <= rx_byte_p1;
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            rx_wptr  <= '0;
            rx_rptr  <= '0;
            rx_count <= '0;
        end else if (rx_flush) begin
            rx_wptr  <= '0;
            rx_rptr  <= '0;
            rx_count <= '0;
        end else begin
            if (rx_wr)  rx_wptr <= rx_wptr + RX_AW'(1);
            if (rx_pop) rx_rptr <= rx_rptr + RX_AW'(1);
            rx_count <= rx_count + (RX_AW+1)'(rx_wr) - (RX_AW+1)'(rx_pop);
        end
    end

endmodule
